// File: rtl/sseg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sseg_pkg                                                     |
// | Description : Shared scan states, segment patterns and BCD decode helper.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sseg_pkg;

    typedef enum logic [0:0] {
        DEAD  = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    // Segment order {a,b,c,d,e,f,g}, active-low
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] value);
        case (value)
            4'd0:    bcd_to_seg = SEG_0;
            4'd1:    bcd_to_seg = SEG_1;
            4'd2:    bcd_to_seg = SEG_2;
            4'd3:    bcd_to_seg = SEG_3;
            4'd4:    bcd_to_seg = SEG_4;
            4'd5:    bcd_to_seg = SEG_5;
            4'd6:    bcd_to_seg = SEG_6;
            4'd7:    bcd_to_seg = SEG_7;
            4'd8:    bcd_to_seg = SEG_8;
            4'd9:    bcd_to_seg = SEG_9;
            default: bcd_to_seg = SEG_DASH;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_digit_encode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sseg_digit_encode                                            |
// | Description : One-digit BCD to active-low {a..g,dp} pattern with blanking. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sseg_digit_encode
    import sseg_pkg::*;
(
    input  logic [3:0] value_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] sseg_o
);

    assign sseg_o = blank_i ? {SEG_BLANK, 1'b1} : {bcd_to_seg(value_i), ~dp_i};

endmodule
`default_nettype wire

// File: rtl/sseg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sseg_scan_driver                                             |
// | Description : N-digit multiplexed 7-seg scanner with dead time, frame      |
// |               snapshot, leading-zero blanking and registered outputs.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int SCAN_CYCLES      = 50000,
    parameter int DEAD_CYCLES      = 500,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [7:0]              sseg,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_tick
);

    localparam int c_MAX_CYC = (SCAN_CYCLES > DEAD_CYCLES) ? SCAN_CYCLES : DEAD_CYCLES;
    localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;
    localparam int c_IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_CNT_W-1:0]    c_SCAN_LAST = c_CNT_W'(SCAN_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]    c_DEAD_LAST = c_CNT_W'(DEAD_CYCLES - 1);
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST  = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

    scan_state_e             state_q, state_d;
    logic [c_IDX_W-1:0]      idx_q, idx_d;
    logic [c_CNT_W-1:0]      presc_q, presc_d;
    logic                    run_q, run_d;
    logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                    snap_blz_q, snap_blz_d;
    logic [7:0]              sseg_q, sseg_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    frame_tick_q, frame_tick_d;

    logic [NUM_DIGITS-1:0]   w_blank;
    logic [7:0]              w_enc;

    // A digit is blanked only if it and every more-significant digit is a bare zero
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        w_blank  = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run & (snap_digits_q[4*i +: 4] == 4'd0) & ~snap_dp_q[i];
            w_blank[i] = snap_blz_q & zero_run;
        end
    end

    // Outputs are registered from next-state, so the encoder looks at idx_d
    sseg_digit_encode u_encode (
        .value_i (snap_digits_q[4*idx_d +: 4]),
        .dp_i    (snap_dp_q[idx_d]),
        .blank_i (w_blank[idx_d]),
        .sseg_o  (w_enc)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        presc_d       = presc_q + 1'b1;
        run_d         = run_q;
        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        snap_blz_d    = snap_blz_q;
        frame_tick_d  = 1'b0;

        if (!enable) begin
            state_d = DEAD;
            idx_d   = '0;
            presc_d = '0;
            run_d   = 1'b0;
        end else if (!run_q) begin
            // First enabled cycle after reset or disable opens a fresh frame
            state_d       = DEAD;
            idx_d         = '0;
            presc_d       = '0;
            run_d         = 1'b1;
            frame_tick_d  = 1'b1;
            snap_digits_d = digits_in;
            snap_dp_d     = dp_in;
            snap_blz_d    = blank_lz;
        end else begin
            case (state_q)
                DEAD: begin
                    if (presc_q == c_DEAD_LAST) begin
                        state_d = DRIVE;
                        presc_d = '0;
                    end
                end
                DRIVE: begin
                    if (presc_q == c_SCAN_LAST) begin
                        state_d = DEAD;
                        presc_d = '0;
                        if (idx_q == c_IDX_LAST) begin
                            idx_d         = '0;
                            frame_tick_d  = 1'b1;
                            snap_digits_d = digits_in;
                            snap_dp_d     = dp_in;
                            snap_blz_d    = blank_lz;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = DEAD;
            endcase
        end

        if (state_d == DRIVE) begin
            sseg_d  = w_enc;
            anode_d = c_ANODE_OFF ^ (NUM_DIGITS'(1) << idx_d);
        end else begin
            sseg_d  = 8'hFF;
            anode_d = c_ANODE_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= DEAD;
            idx_q         <= '0;
            presc_q       <= '0;
            run_q         <= 1'b0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_blz_q    <= 1'b0;
            sseg_q        <= 8'hFF;
            anode_q       <= c_ANODE_OFF;
            frame_tick_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            presc_q       <= presc_d;
            run_q         <= run_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            snap_blz_q    <= snap_blz_d;
            sseg_q        <= sseg_d;
            anode_q       <= anode_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign sseg       = sseg_q;
    assign anode      = anode_q;
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sseg_scan_driver                                          |
// | Description : Directed self-checking bench for sseg_scan_driver (4 digits).|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sseg_scan_driver;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [7:0]  sseg;
    logic [3:0]  anode;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    sseg_scan_driver #(
        .NUM_DIGITS       (4),
        .SCAN_CYCLES      (4),
        .DEAD_CYCLES      (1),
        .ANODE_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .sseg       (sseg),
        .anode      (anode),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts on a frame_tick cycle, walks all slots, ends on the next frame_tick cycle.
    // New inputs are applied at the first drive cycle of apply_slot (-1 = never).
    task automatic do_frame(input string tag, input logic [31:0] segs,
                            input logic [15:0] nd, input logic [3:0] ndp,
                            input logic nblz, input int apply_slot);
        logic [3:0] a_exp;
        check({tag, " tick"}, frame_tick, 1);
        check({tag, " dead0 anode"}, anode, 4'hF);
        check({tag, " dead0 sseg"}, sseg, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                step();
                check($sformatf("%s dead%0d anode", tag, i), anode, 4'hF);
                check($sformatf("%s dead%0d sseg", tag, i), sseg, 8'hFF);
                check($sformatf("%s dead%0d tick", tag, i), frame_tick, 0);
            end
            a_exp = ~(4'b0001 << i);
            for (int c = 0; c < 4; c++) begin
                step();
                if (i == apply_slot && c == 0) begin
                    digits_in = nd;
                    dp_in     = ndp;
                    blank_lz  = nblz;
                end
                check($sformatf("%s d%0d c%0d anode", tag, i, c), anode, a_exp);
                check($sformatf("%s d%0d c%0d sseg", tag, i, c), sseg, segs[i*8 +: 8]);
            end
        end
        step();
        check({tag, " next tick at 20"}, frame_tick, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n)
            check("anode_overlap", 32'($countones(~anode) > 1), 0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        digits_in = 16'h1234;
        dp_in     = 4'b0000;
        blank_lz  = 1'b0;
        repeat (3) step();
        check("reset anode", anode, 4'hF);
        check("reset sseg", sseg, 8'hFF);
        check("reset tick", frame_tick, 0);

        rst_n = 1'b1;
        step();
        do_frame("scan1234", 32'h9F250D99, 16'h0005, 4'b0000, 1'b1, 3);
        do_frame("blank5",   32'hFFFFFF49, 16'h0005, 4'b0010, 1'b1, 3);
        do_frame("blankdp",  32'hFFFF0249, 16'h000A, 4'b0000, 1'b0, 3);
        do_frame("dash",     32'h030303FD, 16'h000A, 4'b0001, 1'b0, 3);
        do_frame("dashdp",   32'h030303FC, 16'h1234, 4'b0000, 1'b0, 3);
        do_frame("coherent", 32'h9F250D99, 16'h9999, 4'b0000, 1'b0, 1);
        do_frame("nines",    32'h09090909, 16'h1234, 4'b0000, 1'b0, 3);

        // Advance into the first drive cycle of digit 2, then drop enable
        repeat (11) step();
        check("slot2 anode", anode, 4'b1011);
        enable = 1'b0;
        step();
        check("disable anode", anode, 4'hF);
        check("disable sseg", sseg, 8'hFF);
        check("disable tick", frame_tick, 0);
        repeat (3) step();
        check("held anode", anode, 4'hF);
        check("held tick", frame_tick, 0);
        enable = 1'b1;
        step();
        do_frame("restart", 32'h9F250D99, 16'h1234, 4'b0000, 1'b0, -1);

        repeat (2) step();
        check("pre-reset anode", anode, 4'b1110);
        rst_n = 1'b0;
        #1;
        check("async reset anode", anode, 4'hF);
        check("async reset sseg", sseg, 8'hFF);
        check("async reset tick", frame_tick, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        do_frame("post_reset", 32'h9F250D99, 16'h1234, 4'b0000, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
Time-multiplexed N-digit seven-segment display driver for the stopwatch and counter displays. It takes packed BCD digits and per-digit decimal-point enables and scans one digit at a time onto a shared active-low segment bus, with per-digit anode enables. It adds features the single-digit decoder lacks: scan timing, anti-ghosting dead time, frame-coherent input snapshot, leading-zero blanking and invalid-code indication.

Parameters:
NUM_DIGITS, 4, number of digits scanned; must be at least 1.
SCAN_CYCLES, 50000, clock cycles each digit is driven; must be at least 1.
DEAD_CYCLES, 500, clock cycles all anodes are off before each digit; must be at least 1.
ANODE_ACTIVE_LOW, 1, 1 drives the active anode as 0; 0 drives it as 1.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  scanning enable
digits_in  in  4*NUM_DIGITS  packed BCD values; digit i occupies bits [4i+3:4i]; digit 0 is least significant and rightmost
dp_in  in  NUM_DIGITS  decimal-point enable per digit, 1 = lit
blank_lz  in  1  1 = leading-zero blanking on
sseg  out  8  {a,b,c,d,e,f,g,dp}; all bits active-low (0 = segment lit)
anode  out  NUM_DIGITS  digit enables, polarity set by ANODE_ACTIVE_LOW
frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- Reset and clock: one clock domain; reset is asynchronous and active-low. All outputs are registered.
- Reset values: sseg = 8'hFF; anode = all inactive; frame_tick = 0; state = DEAD; digit index = 0; prescaler = 0; snapshot = 0.
- State machine: two states, DEAD and DRIVE.
  - DEAD lasts DEAD_CYCLES clocks. anode is all inactive and sseg = 8'hFF.
  - DRIVE lasts SCAN_CYCLES clocks. Only anode[idx] is active, and sseg holds the encoding for digit idx.
  - DEAD is followed by DRIVE on the same idx.
  - DRIVE is followed by DEAD with idx+1, wrapping from NUM_DIGITS-1 to 0.
- Frame period is NUM_DIGITS*(DEAD_CYCLES+SCAN_CYCLES) clocks. The prescaler width is clog2 of max(DEAD_CYCLES, SCAN_CYCLES).
- Snapshot: on the first DEAD cycle of idx 0, digits_in, dp_in and blank_lz are registered into a snapshot, and frame_tick is 1 for that cycle. The display uses only the snapshot, so input changes mid-frame do not appear until the next frame.
- Encoding, segment bits a..g:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - codes 10..15 show a dash, 1111110.
  - The dp bit is ~dp_snapshot[idx].
- Leading-zero blanking: digit i is blanked when blank_lz is 1, i > 0, and every digit j >= i has value 0 and dp 0.
  - A blanked digit drives sseg = 8'hFF while its anode is still asserted, so slot timing is uniform.
  - Digit 0 is never blanked.
  - A digit with its dp lit is never blanked, so "0.5" displays correctly.
- enable low:
  - On the next clock: outputs are blank, anode is inactive, state = DEAD, idx = 0, prescaler = 0, frame_tick = 0.
  - While enable stays low, the block is held there.
  - The first cycle with enable high starts a new frame: snapshot is taken and frame_tick pulses.
- Reset mid-operation: outputs go immediately to their reset values, asynchronously. Recovery matches the enable-high restart.
- No two anodes are ever active in the same cycle. Each transition between active anodes contains at least DEAD_CYCLES blank cycles.

Decomposition:
- Shared package sseg_pkg holds:
  - the state enum {DEAD, DRIVE}
  - segment-pattern constants SEG_0..SEG_9, SEG_DASH and SEG_BLANK (7'b1111111)
  - the function that maps a 4-bit BCD value to a 7-bit pattern.
- One natural sub-module, sseg_digit_encode: combinational, inputs (value[3:0], dp, blank), output sseg[7:0].
- sseg_scan_driver holds the FSM, prescaler, index counter, snapshot, blanking logic and the output registers.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_CYCLES=4, DEAD_CYCLES=1, ANODE_ACTIVE_LOW=1, enable=1, blank_lz=0 unless stated.

1. Reset and first slot: hold rst_n=0 → anode=4'b1111, sseg=8'hFF. Release with digits_in=16'h1234, dp_in=0 → 1 blank cycle with frame_tick=1, then 4 cycles of anode=4'b1110 and sseg=8'h99.
2. Scan and wrap: same inputs → digits 1, 2, 3 are driven with anodes 1101, 1011, 0111 and sseg 8'h0D, 8'h25, 8'h9F. The next frame_tick comes exactly 20 cycles after the first.
3. Blanking: blank_lz=1, digits_in=16'h0005, dp_in=0 → digit 0 sseg=8'h49; digits 1..3 sseg=8'hFF with their anodes asserted. With dp_in=4'b0010 → digit 1 sseg=8'h02; digits 2..3 sseg=8'hFF.
4. Snapshot coherence: change digits_in from 16'h1234 to 16'h9999 during the digit 1 slot → digits 1..3 still show 3, 2, 1 in this frame. All digits show 8'h09 after the next frame_tick.
5. Invalid code: digits_in=16'h000A → digit 0 sseg=8'hFD. With dp_in[0]=1 → digit 0 sseg=8'hFC.
6. Disruption:
   - Drop enable during the digit 2 slot → next cycle anode=4'b1111 and sseg=8'hFF. Re-enable → frame_tick pulses and the frame restarts at digit 0.
   - Pulse rst_n low for 1 cycle mid-DRIVE → outputs blank immediately with no anode overlap. The restart sequence matches scenario 1.
